// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared mode encodings, chunk subtract helper and geometry check
package sub_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam int   MAX_CW    = 64;

  // Operands arrive zero-extended; truncating the result to CW+1 bits leaves {bout, diff}.
  function automatic logic [MAX_CW:0] chunk_sub(input logic [MAX_CW-1:0] a,
                                                input logic [MAX_CW-1:0] b,
                                                input logic              bin);
    return {1'b0, a} - {1'b0, b} - {{MAX_CW{1'b0}}, bin};
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (stages > 0) && (width % stages == 0) && (width / stages <= MAX_CW);
  endfunction

endpackage

// File: rtl/sub_unsigned_pipe_if.sv
// rtl/sub_unsigned_pipe_if.sv - operand/result handshake bundle
interface sub_unsigned_pipe_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             borrow;
  logic             zero;

  modport master (
    output in_valid, A, B, mode, out_ready,
    input  in_ready, out_valid, result, borrow, zero
  );

  modport slave (
    input  in_valid, A, B, mode, out_ready,
    output in_ready, out_valid, result, borrow, zero
  );

endinterface

// File: rtl/sub_chunk_stage.sv
// rtl/sub_chunk_stage.sv - one pipeline stage: chunk subtract plus skewed operands
module sub_chunk_stage
  import sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             mode_i,
  input  logic             bin_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] diff_i,
  output logic             valid_o,
  output logic             mode_o,
  output logic             bout_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] diff_o
);

  localparam int CW   = WIDTH / STAGES;
  localparam bit LAST = (IDX == STAGES - 1);

  logic [CW:0]      sub_w;
  logic [WIDTH-1:0] diff_d;

  logic             valid_q, mode_q, bout_q, zero_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;

  assign sub_w = (CW+1)'(chunk_sub(MAX_CW'(a_i[IDX*CW +: CW]),
                                   MAX_CW'(b_i[IDX*CW +: CW]), bin_i));

  // Saturation only applies once the top chunk has produced the final borrow.
  always_comb begin
    diff_d                 = diff_i;
    diff_d[IDX*CW +: CW]   = sub_w[CW-1:0];
    if (LAST && (mode_i == MODE_SAT) && sub_w[CW]) begin
      diff_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      bout_q  <= sub_w[CW];
      zero_q  <= (diff_d == '0);
      a_q     <= a_i;
      b_q     <= b_i;
      diff_q  <= diff_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign bout_o  = bout_q;
  assign zero_o  = zero_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign diff_o  = diff_q;

endmodule

// File: rtl/sub_unsigned_pipe.sv
// rtl/sub_unsigned_pipe.sv - pipelined unsigned A-B with borrow ripple one chunk per clock
module sub_unsigned_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                clk,
  input logic                rst,
  sub_unsigned_pipe_if.slave bus
);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("sub_unsigned_pipe: WIDTH must be a multiple of STAGES");
  end

  logic             en;
  logic             valid_p [STAGES+1];
  logic             mode_p  [STAGES+1];
  logic             bout_p  [STAGES+1];
  logic             zero_p  [STAGES];
  logic [WIDTH-1:0] a_p     [STAGES+1];
  logic [WIDTH-1:0] b_p     [STAGES+1];
  logic [WIDTH-1:0] diff_p  [STAGES+1];

  // One global enable: the whole pipe freezes only while a result waits downstream.
  assign en           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  assign valid_p[0] = bus.in_valid;
  assign mode_p[0]  = bus.mode;
  assign bout_p[0]  = 1'b0;
  assign a_p[0]     = bus.A;
  assign b_p[0]     = bus.B;
  assign diff_p[0]  = '0;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    sub_chunk_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (s)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .valid_i(valid_p[s]),
      .mode_i (mode_p[s]),
      .bin_i  (bout_p[s]),
      .a_i    (a_p[s]),
      .b_i    (b_p[s]),
      .diff_i (diff_p[s]),
      .valid_o(valid_p[s+1]),
      .mode_o (mode_p[s+1]),
      .bout_o (bout_p[s+1]),
      .zero_o (zero_p[s]),
      .a_o    (a_p[s+1]),
      .b_o    (b_p[s+1]),
      .diff_o (diff_p[s+1])
    );
  end

  assign bus.out_valid = valid_p[STAGES];
  assign bus.result    = diff_p[STAGES];
  assign bus.borrow    = bout_p[STAGES];
  assign bus.zero      = zero_p[STAGES-1];

endmodule

// File: tb/tb_sub_unsigned_pipe.sv
// tb/tb_sub_unsigned_pipe.sv - randomized scoreboard bench for sub_unsigned_pipe
module tb_sub_unsigned_pipe;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         brw;
    logic         zr;
    int           acc;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_unsigned_pipe_if #(.WIDTH(W))  bus ();
  sub_unsigned_pipe_if #(.WIDTH(8))  bus8 ();
  sub_unsigned_pipe_if #(.WIDTH(32)) bus32 ();

  sub_unsigned_pipe #(.WIDTH(W),  .STAGES(S)) dut   (.clk(clk), .rst(rst), .bus(bus));
  sub_unsigned_pipe #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  sub_unsigned_pipe #(.WIDTH(32), .STAGES(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  function automatic exp_t model(input int unsigned a, input int unsigned b, input bit m);
    exp_t        e;
    int unsigned d;
    d     = (a + 65536 - b) % 65536;
    e.brw = (a < b);
    e.res = (m && e.brw) ? '0 : W'(d);
    e.zr  = (e.res == 0);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  logic         pv_stall = 1'b0;
  logic [W-1:0] p_res;
  logic         p_brw, p_zr;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv_stall <= 1'b0;
    end else begin
      checks++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b, want %b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (pv_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== p_res || bus.borrow !== p_brw || bus.zero !== p_zr) begin
          errors++;
          $display("FAIL stall_hold: got v=%b r=%h b=%b z=%b, want v=1 r=%h b=%b z=%b",
                   bus.out_valid, bus.result, bus.borrow, bus.zero, p_res, p_brw, p_zr);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got r=%h, want no output", bus.result);
        end else begin
          e = exp_q.pop_front();
          if (bus.result !== e.res || bus.borrow !== e.brw || bus.zero !== e.zr) begin
            errors++;
            $display("FAIL result: got r=%h b=%b z=%b, want r=%h b=%b z=%b",
                     bus.result, bus.borrow, bus.zero, e.res, e.brw, e.zr);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.acc != S) begin
              errors++;
              $display("FAIL latency: got %0d, want %0d", cyc - e.acc, S);
            end
          end
        end
      end
      pv_stall <= bus.out_valid && !bus.out_ready;
      p_res    <= bus.result;
      p_brw    <= bus.borrow;
      p_zr     <= bus.zero;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    int   n = 0;
    bit   ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.mode     = m;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      e     = model(a, b, m);
      e.acc = cyc;
      e.lat = (bp == 0);
      exp_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  initial begin
    int n;
    int cyc0;
    logic [7:0] hi;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.mode = 1'b0; bus8.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.mode = 1'b0; bus32.out_ready = 1'b1;

    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.borrow !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h b=%b z=%b, want all 0",
               bus.out_valid, bus.result, bus.borrow, bus.zero);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send(16'd50000, 16'd15000, 1'b0);
    drain();

    send(16'h0000, 16'h0001, 1'b0);
    send(16'h0000, 16'h0001, 1'b1);
    send(16'h0100, 16'h0001, 1'b0);
    send(16'h0000, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h1234, 16'h1234, 1'b1);
    send(16'h8000, 16'h8001, 1'b1);
    send(16'h8001, 16'h8000, 1'b1);
    drain();

    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        hi = 8'($urandom);
        send({hi, 8'(i)}, {($urandom_range(0, 1) == 1) ? hi : 8'($urandom), 8'(j)}, 1'($urandom));
      end
    end
    for (int k = 0; k < 10000; k++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain();

    bp = 1;
    for (int k = 0; k < 40; k++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    bp = 0;
    repeat (2) @(posedge clk);
    #1;

    bp = 2;
    repeat (2) @(posedge clk);
    #1;
    send(16'd9, 16'd4, 1'b0);
    send(16'd1, 16'd2, 1'b0);
    send(16'd3, 16'd3, 1'b1);
    repeat (S) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stalled_before_reset: got out_valid=%b, want 1", bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.borrow !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%h b=%b z=%b, want all 0",
               bus.out_valid, bus.result, bus.borrow, bus.zero);
    end
    exp_q.delete();
    bp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_after_reset: got %b, want 1", bus.in_ready);
    end
    repeat (8) @(posedge clk);
    #1;
    send(16'd7, 16'd3, 1'b0);
    drain();

    bus8.in_valid = 1'b1; bus8.A = 8'hFF; bus8.B = 8'hFF;
    @(negedge clk);
    cyc0 = cyc;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.out_valid && n < 30);
    checks++;
    if (bus8.out_valid !== 1'b1 || cyc - cyc0 != 1 || bus8.result !== 8'h00 || bus8.borrow !== 1'b0 || bus8.zero !== 1'b1) begin
      errors++;
      $display("FAIL w8_s1: got v=%b lat=%0d r=%h b=%b z=%b, want v=1 lat=1 r=00 b=0 z=1",
               bus8.out_valid, cyc - cyc0, bus8.result, bus8.borrow, bus8.zero);
    end
    @(posedge clk);
    #1;

    bus32.in_valid = 1'b1; bus32.A = 32'hFFFF_FFFF; bus32.B = 32'hFFFF_FFFF;
    @(negedge clk);
    cyc0 = cyc;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus32.out_valid && n < 30);
    checks++;
    if (bus32.out_valid !== 1'b1 || cyc - cyc0 != 8 || bus32.result !== 32'h0 || bus32.borrow !== 1'b0 || bus32.zero !== 1'b1) begin
      errors++;
      $display("FAIL w32_s8: got v=%b lat=%0d r=%h b=%b z=%b, want v=1 lat=8 r=0 b=0 z=1",
               bus32.out_valid, cyc - cyc0, bus32.result, bus32.borrow, bus32.zero);
    end
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
